// File: rtl/uart_dma_ctrl_pkg.sv
// Shared types and watermark decode for the PL011-style DMA request sequencer.
// Optional error blocking of the RX channel is compiled in with UART_DMA_ONERR_EN.
package uart_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CLRWAIT = 2'd2
    } dma_state_e;

    localparam logic [2:0] IFLS_1_8 = 3'b000;
    localparam logic [2:0] IFLS_1_4 = 3'b001;
    localparam logic [2:0] IFLS_1_2 = 3'b010;
    localparam logic [2:0] IFLS_3_4 = 3'b011;
    localparam logic [2:0] IFLS_7_8 = 3'b100;

    // Reserved selects (101..111) fall back to the half-full watermark.
    function automatic int ifls_threshold(input logic [2:0] sel, input int depth);
        int k;
        case (sel)
            IFLS_1_8: k = 1;
            IFLS_1_4: k = 2;
            IFLS_1_2: k = 4;
            IFLS_3_4: k = 6;
            IFLS_7_8: k = 7;
            default:  k = 4;
        endcase
        return (depth * k) / 8;
    endfunction

endpackage

// File: rtl/uart_dma_ctrl_if.sv
// DMA pin bundle between the UART request sequencer and the DMA controller.
// valid/ready: a request (SREQ/BREQ) stays high until the DMA answers with CLR, or the condition goes away.
interface uart_dma_ctrl_if;
    logic UARTTXDMASREQ;
    logic UARTTXDMABREQ;
    logic UARTRXDMASREQ;
    logic UARTRXDMABREQ;
    logic UARTTXDMACLR;
    logic UARTRXDMACLR;

    modport master (
        output UARTTXDMASREQ, UARTTXDMABREQ, UARTRXDMASREQ, UARTRXDMABREQ,
        input  UARTTXDMACLR, UARTRXDMACLR
    );

    modport slave (
        input  UARTTXDMASREQ, UARTTXDMABREQ, UARTRXDMASREQ, UARTRXDMABREQ,
        output UARTTXDMACLR, UARTRXDMACLR
    );
endinterface

// File: rtl/uart_dma_ctrl_chan.sv
// One DMA request channel: IDLE/REQ/CLRWAIT sequencing of a single/burst request pair.
// Generic s/b conditions; the top decides what they mean for TX or RX.
module uart_dma_chan
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       s,
    input  logic       b,
    input  logic       clr,
    output logic       sreq,
    output logic       breq,
    output dma_state_e state_dbg
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_CLRWAIT = 2'd2;

    logic [1:0] state;

    assign state_dbg = dma_state_e'(state);

    // Requests default low; only the REQ path (or entry to it) raises them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            sreq  <= 1'b0;
            breq  <= 1'b0;
        end else begin
            sreq <= 1'b0;
            breq <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (en && (s || b)) begin
                        state <= S_REQ;
                        sreq  <= s;
                        breq  <= b;
                    end
                end
                S_REQ: begin
                    if (!en) begin
                        state <= S_IDLE;
                    end else if (clr) begin
                        state <= S_CLRWAIT;
                    end else if (!(s || b)) begin
                        state <= S_IDLE;
                    end else begin
                        sreq <= s;
                        breq <= b;
                    end
                end
                S_CLRWAIT: begin
                    if (!en || !clr) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_dma_ctrl.sv
// DMA request sequencer top: FIFO-level conditions for TX and RX, two channel FSMs.
// Define UART_DMA_ONERR_EN to block RX requests after an RX error until RXDMAE is cleared.
module uart_dma_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             FEN,
    input  logic             TXDMAE,
    input  logic             RXDMAE,
    input  logic [2:0]       TXIFLSEL,
    input  logic [2:0]       RXIFLSEL,
    input  logic [LVL_W-1:0] TX_LEVEL,
    input  logic [LVL_W-1:0] RX_LEVEL,
    input  logic             RX_ERR,
    uart_dma_ctrl_if.master  dma,
    output dma_state_e       tx_state,
    output dma_state_e       rx_state
);

    logic [LVL_W-1:0] tx_t;
    logic [LVL_W-1:0] rx_t;
    logic [LVL_W-1:0] depth_eff;
    logic             tx_s, tx_b, rx_s, rx_b;
    logic             rx_en;

    assign tx_t      = LVL_W'(ifls_threshold(TXIFLSEL, FIFO_DEPTH));
    assign rx_t      = LVL_W'(ifls_threshold(RXIFLSEL, FIFO_DEPTH));
    // With the FIFO off the holding register behaves as a one-entry FIFO.
    assign depth_eff = FEN ? LVL_W'(FIFO_DEPTH) : LVL_W'(1);

    assign tx_s = TX_LEVEL < depth_eff;
    assign tx_b = FEN && (TX_LEVEL <= tx_t);
    assign rx_s = RX_LEVEL >= LVL_W'(1);
    assign rx_b = FEN && (RX_LEVEL >= rx_t);

`ifdef UART_DMA_ONERR_EN
    logic rx_err_blk;

    always_ff @(posedge PCLK) begin
        if (PRESET || !RXDMAE) begin
            rx_err_blk <= 1'b0;
        end else if (RX_ERR) begin
            rx_err_blk <= 1'b1;
        end
    end

    // The error pulse itself masks too, so the channel drops on the very next edge.
    assign rx_en = RXDMAE && !rx_err_blk && !RX_ERR;
`else
    logic rx_err_unused;

    assign rx_err_unused = RX_ERR;
    assign rx_en         = RXDMAE;
`endif

    uart_dma_chan u_tx (
        .clk       (PCLK),
        .rst       (PRESET),
        .en        (TXDMAE),
        .s         (tx_s),
        .b         (tx_b),
        .clr       (dma.UARTTXDMACLR),
        .sreq      (dma.UARTTXDMASREQ),
        .breq      (dma.UARTTXDMABREQ),
        .state_dbg (tx_state)
    );

    uart_dma_chan u_rx (
        .clk       (PCLK),
        .rst       (PRESET),
        .en        (rx_en),
        .s         (rx_s),
        .b         (rx_b),
        .clr       (dma.UARTRXDMACLR),
        .sreq      (dma.UARTRXDMASREQ),
        .breq      (dma.UARTRXDMABREQ),
        .state_dbg (rx_state)
    );

endmodule

// File: tb/tb_uart_dma_ctrl.sv
// Directed bench for uart_dma_ctrl: watermarks, CLR handshake, enables, FEN=0 and error blocking.
module tb_uart_dma_ctrl;
    import uart_pkg::*;

    localparam int FIFO_DEPTH = 32;
    localparam int LVL_W      = 6;

    logic             clk = 1'b0;
    logic             PRESET;
    logic             FEN, TXDMAE, RXDMAE, RX_ERR;
    logic [2:0]       TXIFLSEL, RXIFLSEL;
    logic [LVL_W-1:0] TX_LEVEL, RX_LEVEL;
    dma_state_e       tx_state, rx_state;
    logic [1:0]       tx_sb, rx_sb;

    int n_run  = 0;
    int n_fail = 0;

    uart_dma_ctrl_if bus ();

    uart_dma_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) dut (
        .PCLK     (clk),
        .PRESET   (PRESET),
        .FEN      (FEN),
        .TXDMAE   (TXDMAE),
        .RXDMAE   (RXDMAE),
        .TXIFLSEL (TXIFLSEL),
        .RXIFLSEL (RXIFLSEL),
        .TX_LEVEL (TX_LEVEL),
        .RX_LEVEL (RX_LEVEL),
        .RX_ERR   (RX_ERR),
        .dma      (bus.master),
        .tx_state (tx_state),
        .rx_state (rx_state)
    );

    assign tx_sb = {bus.UARTTXDMASREQ, bus.UARTTXDMABREQ};
    assign rx_sb = {bus.UARTRXDMASREQ, bus.UARTRXDMABREQ};

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        PRESET = 1'b1; FEN = 1'b1; TXDMAE = 1'b1; RXDMAE = 1'b0; RX_ERR = 1'b0;
        TXIFLSEL = 3'b010; RXIFLSEL = 3'b000; TX_LEVEL = '0; RX_LEVEL = '0;
        bus.UARTTXDMACLR = 1'b0; bus.UARTRXDMACLR = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_run++;
            if ({tx_sb, rx_sb} !== 4'b0000) begin
                $display("FAIL reset_outputs cycle %0d: got %b want 0000", i, {tx_sb, rx_sb});
                n_fail++;
            end
        end
        PRESET = 1'b0;
        step();
        n_run++;
        if (tx_sb !== 2'b11) begin
            $display("FAIL reset_release_tx: got %b want 11", tx_sb); n_fail++;
        end
        n_run++;
        if (tx_state !== REQ) begin
            $display("FAIL reset_release_state: got %0d want %0d", tx_state, REQ); n_fail++;
        end
    endtask

    task automatic test_tx_watermark();
        logic [LVL_W-1:0] lv[3]  = '{6'd16, 6'd17, 6'd32};
        logic [1:0]       exp[3] = '{2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            TX_LEVEL = lv[i];
            step();
            n_run++;
            if (tx_sb !== exp[i]) begin
                $display("FAIL tx_wm lvl=%0d: got %b want %b", lv[i], tx_sb, exp[i]); n_fail++;
            end
        end
        n_run++;
        if (tx_state !== IDLE) begin
            $display("FAIL tx_full_idle: got %0d want %0d", tx_state, IDLE); n_fail++;
        end
        TXIFLSEL = 3'b000; TX_LEVEL = 6'd5;
        step();
        n_run++;
        if (tx_sb !== 2'b10) begin
            $display("FAIL tx_wm_t4_lvl5: got %b want 10", tx_sb); n_fail++;
        end
        TX_LEVEL = 6'd4;
        step();
        n_run++;
        if (tx_sb !== 2'b11) begin
            $display("FAIL tx_wm_t4_lvl4: got %b want 11", tx_sb); n_fail++;
        end
        TXDMAE = 1'b0;
        step();
    endtask

    task automatic test_rx_clr();
        RXDMAE = 1'b1; RXIFLSEL = 3'b000; RX_LEVEL = 6'd4;
        step();
        n_run++;
        if (rx_sb !== 2'b11) begin
            $display("FAIL rx_req_lvl4: got %b want 11", rx_sb); n_fail++;
        end
        bus.UARTRXDMACLR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_run++;
            if (rx_sb !== 2'b00 || rx_state !== CLRWAIT) begin
                $display("FAIL rx_clr_hold cycle %0d: got %b/%0d want 00/%0d", i, rx_sb, rx_state, CLRWAIT);
                n_fail++;
            end
        end
        bus.UARTRXDMACLR = 1'b0;
        step();
        n_run++;
        if (rx_sb !== 2'b00 || rx_state !== IDLE) begin
            $display("FAIL rx_clr_gap: got %b/%0d want 00/%0d", rx_sb, rx_state, IDLE); n_fail++;
        end
        step();
        n_run++;
        if (rx_sb !== 2'b11) begin
            $display("FAIL rx_reassert: got %b want 11", rx_sb); n_fail++;
        end
        RX_LEVEL = 6'd3;
        step();
        n_run++;
        if (rx_sb !== 2'b10) begin
            $display("FAIL rx_below_t: got %b want 10", rx_sb); n_fail++;
        end
        RX_LEVEL = 6'd0;
        step();
        n_run++;
        if (rx_sb !== 2'b00 || rx_state !== IDLE) begin
            $display("FAIL rx_empty: got %b/%0d want 00/%0d", rx_sb, rx_state, IDLE); n_fail++;
        end
    endtask

    task automatic test_thresholds();
        logic [2:0]       sel[5] = '{3'b100, 3'b100, 3'b111, 3'b111, 3'b011};
        logic [LVL_W-1:0] lv[5]  = '{6'd27, 6'd28, 6'd15, 6'd16, 6'd24};
        logic [1:0]       exp[5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b11};
        for (int i = 0; i < 5; i++) begin
            RXIFLSEL = sel[i]; RX_LEVEL = lv[i];
            step();
            n_run++;
            if (rx_sb !== exp[i]) begin
                $display("FAIL rx_thr sel=%b lvl=%0d: got %b want %b", sel[i], lv[i], rx_sb, exp[i]);
                n_fail++;
            end
        end
        RX_LEVEL = '0;
        step();
    endtask

    task automatic test_fifo_disabled();
        FEN = 1'b0; RXIFLSEL = 3'b000; RX_LEVEL = 6'd8;
        step();
        n_run++;
        if (rx_sb !== 2'b10) begin
            $display("FAIL fen0_rx_lvl8: got %b want 10", rx_sb); n_fail++;
        end
        RX_LEVEL = 6'd1;
        step();
        n_run++;
        if (rx_sb !== 2'b10) begin
            $display("FAIL fen0_rx_lvl1: got %b want 10", rx_sb); n_fail++;
        end
        TXDMAE = 1'b1; TXIFLSEL = 3'b000; TX_LEVEL = 6'd1;
        step();
        n_run++;
        if (tx_sb !== 2'b00) begin
            $display("FAIL fen0_tx_lvl1: got %b want 00", tx_sb); n_fail++;
        end
        TX_LEVEL = 6'd0;
        step();
        n_run++;
        if (tx_sb !== 2'b10) begin
            $display("FAIL fen0_tx_lvl0: got %b want 10", tx_sb); n_fail++;
        end
        FEN = 1'b1;
        step();
        n_run++;
        if (tx_sb !== 2'b11 || tx_state !== REQ) begin
            $display("FAIL fen_toggle_tx: got %b/%0d want 11/%0d", tx_sb, tx_state, REQ); n_fail++;
        end
        TXDMAE = 1'b0; RXDMAE = 1'b0; RX_LEVEL = '0;
        step();
    endtask

    task automatic test_enable_priority();
        FEN = 1'b1; TXIFLSEL = 3'b010; TX_LEVEL = 6'd8; TXDMAE = 1'b1;
        step();
        n_run++;
        if (tx_sb !== 2'b11) begin
            $display("FAIL en_tx_req: got %b want 11", tx_sb); n_fail++;
        end
        TXDMAE = 1'b0;
        step();
        n_run++;
        if (tx_sb !== 2'b00 || tx_state !== IDLE) begin
            $display("FAIL en_drop: got %b/%0d want 00/%0d", tx_sb, tx_state, IDLE); n_fail++;
        end
        TXDMAE = 1'b1;
        step();
        bus.UARTTXDMACLR = 1'b1; TX_LEVEL = 6'd20;
        step();
        n_run++;
        if (tx_sb !== 2'b00 || tx_state !== CLRWAIT) begin
            $display("FAIL clr_priority: got %b/%0d want 00/%0d", tx_sb, tx_state, CLRWAIT); n_fail++;
        end
        bus.UARTTXDMACLR = 1'b0;
        step();
        step();
        n_run++;
        if (tx_sb !== 2'b10) begin
            $display("FAIL tx_after_clr_lvl20: got %b want 10", tx_sb); n_fail++;
        end
        TX_LEVEL = 6'd32;
        step();
        TX_LEVEL = 6'd8; bus.UARTTXDMACLR = 1'b1;
        step();
        n_run++;
        if (tx_sb !== 2'b11 || tx_state !== REQ) begin
            $display("FAIL clr_in_idle: got %b/%0d want 11/%0d", tx_sb, tx_state, REQ); n_fail++;
        end
        bus.UARTTXDMACLR = 1'b0;
        step();
    endtask

    task automatic test_onerr();
        RXDMAE = 1'b1; RXIFLSEL = 3'b000; RX_LEVEL = 6'd8;
        step();
        n_run++;
        if (rx_sb !== 2'b11 || tx_sb !== 2'b11) begin
            $display("FAIL onerr_pre: got rx %b tx %b want 11 11", rx_sb, tx_sb); n_fail++;
        end
        RX_ERR = 1'b1;
        step();
        RX_ERR = 1'b0;
        for (int i = 0; i < 3; i++) begin
`ifdef UART_DMA_ONERR_EN
            n_run++;
            if (rx_sb !== 2'b00 || tx_sb !== 2'b11) begin
                $display("FAIL onerr_block cycle %0d: got rx %b tx %b want 00 11", i, rx_sb, tx_sb); n_fail++;
            end
`else
            n_run++;
            if (rx_sb !== 2'b11 || tx_sb !== 2'b11) begin
                $display("FAIL err_ignored cycle %0d: got rx %b tx %b want 11 11", i, rx_sb, tx_sb); n_fail++;
            end
`endif
            step();
        end
        RXDMAE = 1'b0;
        step();
        RXDMAE = 1'b1;
        step();
        n_run++;
        if (rx_sb !== 2'b11 || tx_sb !== 2'b11) begin
            $display("FAIL onerr_restore: got rx %b tx %b want 11 11", rx_sb, tx_sb); n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        PRESET = 1'b1;
        step();
        n_run++;
        if ({tx_sb, rx_sb} !== 4'b0000 || tx_state !== IDLE || rx_state !== IDLE) begin
            $display("FAIL reset_mid: got %b states %0d/%0d want 0000 idle", {tx_sb, rx_sb}, tx_state, rx_state);
            n_fail++;
        end
        PRESET = 1'b0;
        step();
        n_run++;
        if (tx_sb !== 2'b11 || rx_sb !== 2'b11) begin
            $display("FAIL reset_mid_resume: got tx %b rx %b want 11 11", tx_sb, rx_sb); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_tx_watermark();
        test_rx_clr();
        test_thresholds();
        test_fifo_disabled();
        test_enable_priority();
        test_onerr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
